counter_sequencer: RTL and testbench

Synchronous run/pause/step controller for the board's small LED counter: turns four debounced push-button levels into counter commands and produces the count shown on the LEDs. A prescaler sets the counting rate, and a programmable terminal value sets where the count wraps. It replaces free-running ripple counting with a fully synchronous, single-clock datapath that the top level can drive directly from buttons and switches.

---
 rtl/counter_seq_pkg.sv | 36 +++
 rtl/tick_prescaler.sv | 30 +++
 rtl/counter_sequencer.sv | 141 ++++++++++++++
 tb/tb_counter_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types for the LED counter sequencer: FSM states, decoded button
// commands and the command priority encoder.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_STOP  = 3'd2,
    CMD_START = 3'd3,
    CMD_STEP  = 3'd4
  } cmd_t;

  // Edge vector order is {clear, stop, start, step}; only the strongest edge is kept.
  function automatic cmd_t cmd_encode(input logic [3:0] edges);
    cmd_t cmd;
    if (edges[3]) begin
      cmd = CMD_CLEAR;
    end else if (edges[2]) begin
      cmd = CMD_STOP;
    end else if (edges[1]) begin
      cmd = CMD_START;
    end else if (edges[0]) begin
      cmd = CMD_STEP;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Rate divider for the RUN state: tick is high on every DIV-th enabled cycle,
// and the phase restarts from 0 whenever en drops.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // Phase counter: wraps on tick, cleared while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/step controller for the LED counter: button edge detection,
// command priority, IDLE/RUN/PAUSE FSM and the wrap-around count datapath.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_step,
  input  logic             btn_clear,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             wrap
);

  logic [3:0]       r_prev;
  logic [3:0]       w_btn;
  logic [3:0]       w_edge;
  cmd_t             w_cmd;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_led;
  logic [WIDTH-1:0] w_led_nxt;
  logic [WIDTH-1:0] w_adv_cnt;
  logic             w_adv_wrap;
  logic             w_wrap_nxt;
  logic             r_running;
  logic             r_wrap;
  logic             w_presc_en;
  logic             w_tick;

  assign w_btn  = {btn_clear, btn_stop, btn_start, btn_step};
  assign w_edge = w_btn & ~r_prev;
  assign w_cmd  = cmd_encode(w_edge);

  // A clear or stop edge in RUN must also restart the prescaler phase.
  assign w_presc_en = (r_state == RUN) && (w_cmd != CMD_CLEAR) && (w_cmd != CMD_STOP);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (w_presc_en),
    .tick  (w_tick)
  );

  // Advance rule: clamping to limit first keeps the count inside 0..limit.
  always_comb begin
    w_adv_cnt  = r_led;
    w_adv_wrap = 1'b0;
    if (up) begin
      if (r_led >= limit) begin
        w_adv_cnt  = '0;
        w_adv_wrap = 1'b1;
      end else begin
        w_adv_cnt  = r_led + WIDTH'(1);
      end
    end else begin
      if (r_led == '0) begin
        w_adv_cnt  = limit;
        w_adv_wrap = 1'b1;
      end else if (r_led > limit) begin
        w_adv_cnt  = limit;
      end else begin
        w_adv_cnt  = r_led - WIDTH'(1);
      end
    end
  end

  // Next-state and next-count logic; ignored commands leave RUN ticking.
  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      IDLE, PAUSE: begin
        case (w_cmd)
          CMD_CLEAR: begin
            w_state_nxt = IDLE;
            w_led_nxt   = '0;
          end
          CMD_START: w_state_nxt = RUN;
          CMD_STEP: begin
            w_state_nxt = PAUSE;
            w_led_nxt   = w_adv_cnt;
            w_wrap_nxt  = w_adv_wrap;
          end
          default: w_state_nxt = r_state;
        endcase
      end
      RUN: begin
        case (w_cmd)
          CMD_CLEAR: begin
            w_state_nxt = IDLE;
            w_led_nxt   = '0;
          end
          CMD_STOP: w_state_nxt = PAUSE;
          default: begin
            if (w_tick) begin
              w_led_nxt  = w_adv_cnt;
              w_wrap_nxt = w_adv_wrap;
            end else begin
              w_led_nxt  = r_led;
            end
          end
        endcase
      end
      default: begin
        w_state_nxt = IDLE;
        w_led_nxt   = '0;
      end
    endcase
  end

  // State and output registers; prev starts high so held buttons are not edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev    <= 4'hF;
      r_state   <= IDLE;
      r_led     <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_prev    <= w_btn;
      r_state   <= w_state_nxt;
      r_led     <= w_led_nxt;
      r_running <= (w_state_nxt == RUN);
      r_wrap    <= w_wrap_nxt;
    end
  end

  assign led     = r_led;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: two sequencers (DIV=4 and DIV=1) share stimulus and are
// compared every cycle against a behavioural model, plus directed checks.
module tb_counter_sequencer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_start, btn_stop, btn_step, btn_clear, up;
  logic [W-1:0] limit;
  logic [W-1:0] led_a, led_b;
  logic         run_a, run_b, wrap_a, wrap_b;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W), .DIV(4)) u_a (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_step(btn_step), .btn_clear(btn_clear), .up(up), .limit(limit),
    .led(led_a), .running(run_a), .wrap(wrap_a)
  );

  counter_sequencer #(.WIDTH(W), .DIV(1)) u_b (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_step(btn_step), .btn_clear(btn_clear), .up(up), .limit(limit),
    .led(led_b), .running(run_b), .wrap(wrap_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = idle, 1 = run, 2 = pause; since = RUN cycles since last advance.
  int       m_mode[2];
  int       m_cnt[2];
  int       m_since[2];
  int       m_wrap[2];
  bit [3:0] m_prev[2];
  int       divs[2] = '{4, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_adv(input int k);
    int lim;
    lim = int'(limit);
    if (up) begin
      if (m_cnt[k] >= lim) begin m_cnt[k] = 0; m_wrap[k] = 1; end
      else m_cnt[k] = m_cnt[k] + 1;
    end else begin
      if (m_cnt[k] == 0) begin m_cnt[k] = lim; m_wrap[k] = 1; end
      else if (m_cnt[k] > lim) m_cnt[k] = lim;
      else m_cnt[k] = m_cnt[k] - 1;
    end
  endfunction

  task automatic model_step(input int k);
    bit [3:0] b, e;
    bit       took;
    if (reset) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_since[k] = 0; m_wrap[k] = 0; m_prev[k] = 4'hF;
      return;
    end
    b = {btn_clear, btn_stop, btn_start, btn_step};
    e = b & ~m_prev[k];
    m_prev[k] = b;
    m_wrap[k] = 0;
    took = 1'b0;
    if (e[3]) begin
      m_mode[k] = 0; m_cnt[k] = 0; took = 1'b1;
    end else if (e[2]) begin
      if (m_mode[k] == 1) begin m_mode[k] = 2; took = 1'b1; end
    end else if (e[1]) begin
      if (m_mode[k] != 1) begin m_mode[k] = 1; m_since[k] = 0; took = 1'b1; end
    end else if (e[0]) begin
      if (m_mode[k] != 1) begin model_adv(k); m_mode[k] = 2; took = 1'b1; end
    end
    if (!took && m_mode[k] == 1) begin
      m_since[k]++;
      if (m_since[k] == divs[k]) begin model_adv(k); m_since[k] = 0; end
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    chk("led_a",  32'(led_a),  m_cnt[0]);
    chk("run_a",  32'(run_a),  (m_mode[0] == 1) ? 1 : 0);
    chk("wrap_a", 32'(wrap_a), m_wrap[0]);
    chk("led_b",  32'(led_b),  m_cnt[1]);
    chk("run_b",  32'(run_b),  (m_mode[1] == 1) ? 1 : 0);
    chk("wrap_b", 32'(wrap_b), m_wrap[1]);
  endtask

  // Button index: 0 step, 1 start, 2 stop, 3 clear. High for one cycle, then low.
  task automatic press(input int which);
    case (which)
      0: btn_step = 1'b1;
      1: btn_start = 1'b1;
      2: btn_stop = 1'b1;
      default: btn_clear = 1'b1;
    endcase
    cycle();
    btn_step = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
    cycle();
  endtask

  task automatic wait_led_a(input int v, input string tag);
    for (int i = 0; i < 64; i++) begin
      if (int'(led_a) == v) break;
      cycle();
    end
    chk(tag, 32'(led_a), v);
  endtask

  initial begin
    int wraps;
    reset = 1'b1; btn_start = 1'b1; btn_stop = 1'b0; btn_step = 1'b0; btn_clear = 1'b0;
    up = 1'b1; limit = 3'd7;
    cycle(); cycle();
    chk("rst_led", 32'(led_a), 0);
    chk("rst_run", 32'(run_a), 0);
    chk("rst_wrap", 32'(wrap_a), 0);

    // Start held through reset must not count as an edge.
    reset = 1'b0;
    repeat (3) cycle();
    chk("held_start_run", 32'(run_a), 0);
    btn_start = 1'b0;
    cycle();

    // Count 1..7,0 at DIV=4 spacing with one wrap.
    press(1);
    wraps = 0;
    for (int i = 0; i < 31; i++) begin
      cycle();
      wraps += int'(wrap_a);
    end
    chk("full_lap_led", 32'(led_a), 0);
    chk("full_lap_wraps", 32'(wraps), 1);
    chk("full_lap_run", 32'(run_a), 1);

    // Pause at 3, resume: 4 appears DIV cycles after the resume edge.
    press(3);
    limit = 3'd5;
    press(1);
    wait_led_a(3, "reach_3");
    press(2);
    chk("pause_led", 32'(led_a), 3);
    chk("pause_run", 32'(run_a), 0);
    cycle();
    press(1);
    cycle(); cycle();
    chk("resume_hold", 32'(led_a), 3);
    cycle();
    chk("resume_adv", 32'(led_a), 4);

    // Down-steps from IDLE: 5 (wrap), 4, 3.
    press(3);
    up = 1'b0; limit = 3'd5;
    press(0); chk("step1", 32'(led_a), 5);
    press(0); chk("step2", 32'(led_a), 4);
    press(0); chk("step3", 32'(led_a), 3);
    chk("step_run", 32'(run_a), 0);

    // Clear and stop together in RUN: clear wins.
    up = 1'b1; limit = 3'd7;
    press(1);
    repeat (6) cycle();
    btn_clear = 1'b1; btn_stop = 1'b1;
    cycle();
    chk("clr_stop_led", 32'(led_a), 0);
    chk("clr_stop_run", 32'(run_a), 0);
    btn_clear = 1'b0; btn_stop = 1'b0;
    cycle();

    // Lower limit below the count while running up.
    press(1);
    wait_led_a(6, "reach_6");
    limit = 3'd4;
    for (int i = 0; i < 8; i++) begin
      if (int'(led_a) != 6) break;
      cycle();
    end
    chk("limit_drop_led", 32'(led_a), 0);
    chk("limit_drop_wrap", 32'(wrap_a), 1);

    // limit=0 at DIV=1: count pinned at 0, wrap every cycle.
    press(3);
    limit = 3'd0;
    press(1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("lim0_led_b", 32'(led_b), 0);
      chk("lim0_wrap_b", 32'(wrap_b), 1);
    end

    // Reset mid-run at led=5.
    press(3);
    limit = 3'd7; up = 1'b1;
    press(1);
    wait_led_a(5, "reach_5");
    reset = 1'b1;
    cycle();
    chk("midrst_led", 32'(led_a), 0);
    chk("midrst_run", 32'(run_a), 0);
    chk("midrst_wrap", 32'(wrap_a), 0);
    reset = 1'b0;
    cycle();

    // Randomized buttons, direction, limit and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      btn_clear = ($urandom_range(0, 23) == 0);
      btn_stop  = ($urandom_range(0, 9) == 0);
      btn_start = ($urandom_range(0, 5) == 0);
      btn_step  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) limit = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
